fetch_stage: RTL

- Front end of the 16-bit vectorial ASIP pipeline; produces the instruction stream that the decode stage consumes.
- Holds the PC and issues word-addressed requests to instruction memory.
- Buffers in-order responses in a small FIFO and hands {instruction, pc} to decode over a valid/ready handshake.
- Accepts PC redirects (PCWriteEn/target from execute), flushing buffered and in-flight fetches.

---
 rtl/asip_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/fetch_stage.sv | 99 +++++++++
 3 files changed

// File: rtl/asip_pkg.sv
// asip_pkg: types and constants shared by the stages of the 16-bit vectorial ASIP pipeline.
package asip_pkg;
    localparam int ADDR_W = 16;
    localparam int INSTR_W = 16;
    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

    typedef logic [INSTR_W-1:0] instr_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef struct packed {
        addr_t  pc;
        instr_t instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries with flush.
// The head is read straight from storage, so it stays stable while not popped.
module fetch_fifo
    import asip_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fetch_entry_t               din,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign empty   = cnt_q == '0;
    assign full    = cnt_q == CW'(DEPTH);
    assign count   = cnt_q;
    assign head    = mem_q[rd_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d = mem_q;
        if (do_push && !flush) mem_d[wr_q] = din;
        wr_d  = flush ? '0 : do_push ? nxt(wr_q) : wr_q;
        rd_d  = flush ? '0 : do_pop ? nxt(rd_q) : rd_q;
        cnt_d = flush ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, credit-limited instruction-memory requests, in-order response buffering
// and redirect handling for the decode stage.
module fetch_stage
    import asip_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               pc_write_en,
    input  logic [ADDR_W-1:0]  pc_target,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  instr_pc
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    addr_t         pc_q, pc_d;
    logic [CW-1:0] out_q, out_d, drop_q, drop_d, buf_cnt, tag_cnt;
    logic [CW:0]   used;
    logic          issue, keep, pop;
    logic          buf_empty, buf_full, tag_empty, tag_full;
    fetch_entry_t  tag_in, tag_head, rsp_entry, buf_head;

    assign used           = {1'b0, out_q} + {1'b0, buf_cnt};
    assign imem_req_valid = !reset && !pc_write_en && used < DEPTH_W;
    assign imem_addr      = pc_q;
    assign issue          = imem_req_valid && imem_req_ready;
    assign keep           = imem_rsp_valid && drop_q == '0 && !pc_write_en;
    assign instr_valid    = !buf_empty && !pc_write_en;
    assign pop            = instr_valid && instr_ready;
    assign instruction    = buf_head.instr;
    assign instr_pc       = buf_head.pc;
    assign tag_in         = '{pc: pc_q, instr: '0};
    assign rsp_entry      = '{pc: tag_head.pc, instr: imem_rsp_data};

    // out_q counts every in-flight request, including ones already marked for
    // dropping, so a redirect simply marks whatever is still in flight afterwards.
    always_comb begin
        pc_d   = pc_write_en ? pc_target : issue ? pc_q + 1'b1 : pc_q;
        out_d  = out_q + CW'(issue) - CW'(imem_rsp_valid);
        drop_d = pc_write_en ? out_q - CW'(imem_rsp_valid)
                             : drop_q - CW'(imem_rsp_valid && drop_q != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            out_q  <= '0;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            out_q  <= out_d;
            drop_q <= drop_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (issue),
        .pop   (imem_rsp_valid),
        .flush (1'b0),
        .din   (tag_in),
        .head  (tag_head),
        .count (tag_cnt),
        .empty (tag_empty),
        .full  (tag_full)
    );

    fetch_fifo #(.DEPTH(DEPTH)) u_buf_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (keep),
        .pop   (pop),
        .flush (pc_write_en),
        .din   (rsp_entry),
        .head  (buf_head),
        .count (buf_cnt),
        .empty (buf_empty),
        .full  (buf_full)
    );

    a_rsp_orphan: assert property (@(posedge clk) disable iff (reset)
        imem_rsp_valid |-> out_q != '0);
    a_buf_overflow: assert property (@(posedge clk) disable iff (reset)
        !(keep && buf_full && !pop));
    a_tag_overflow: assert property (@(posedge clk) disable iff (reset)
        !(issue && tag_full));
    a_tag_track: assert property (@(posedge clk) disable iff (reset)
        tag_cnt == out_q && tag_empty == (out_q == '0) && tag_head.instr == '0);
endmodule
